// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART receive sequencer. Oversamples the asynchronous RX line, detects the
// start bit, times mid-bit samples and steers an external sipo shift
// register through clear/shift strobes. Frames are LSB first: one start bit,
// N data bits, one stop bit. A completed frame is offered on a valid/ready
// handshake.
//
// Parameters
//   N             data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles per bit period (>= 4, even)
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_rx          serial line, idle high (asynchronous)
//   o_sipo_clr    one-cycle clear to the sipo (first START cycle)
//   o_sipo_shift  one-cycle shift strobe to the sipo (mid data bit)
//   o_sipo_data   serial bit for the sipo, meaningful while o_sipo_shift=1
//   i_sipo_q      parallel sipo contents (new bit enters MSB)
//   o_data        received word, stable while o_valid=1
//   o_valid       o_data holds an unconsumed frame
//   i_ready       consumer takes o_data when o_valid & i_ready
//   o_frame_err   one-cycle pulse: stop bit sampled low
//   o_overrun     one-cycle pulse: frame completed but dropped
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx,
  output logic         o_sipo_clr,
  output logic         o_sipo_shift,
  output logic         o_sipo_data,
  input  logic [N-1:0] i_sipo_q,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_frame_err,
  output logic         o_overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(N + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  generate
    if (N < 1 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_param_check
      $error("uart_rx_ctrl: need N >= 1 and CLKS_PER_BIT >= 4 and even");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rx_meta_q, rx_s_q;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sipo_clr, sipo_shift, complete;

  // Two-flop synchronizer; resets to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    sipo_clr   = 1'b0;
    sipo_shift = 1'b0;
    complete   = 1'b0;

    // Consumer handshake; a completion below may re-set valid in the same cycle.
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // START always begins with cnt=0, so this fires exactly once per entry.
        sipo_clr = (cnt_q == '0);
        if (cnt_q == HALF_LAST) begin
          // Line back high at mid start bit: treat as a glitch, silently.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          sipo_shift = 1'b1;
          idx_d      = idx_q + 1'b1;
          cnt_d      = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leaving half a bit early lets a back-to-back start bit be caught.
        if (cnt_q == BIT_LAST) begin
          if (rx_s_q) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end

    // A consumer taking the old word in the stop-sample cycle frees the slot.
    if (complete) begin
      if (!valid_q || i_ready) begin
        data_d  = i_sipo_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_sipo_clr   = sipo_clr;
  assign o_sipo_shift = sipo_shift;
  assign o_sipo_data  = sipo_shift & rx_s_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Drives serial frames with known timing and derives the expected strobes and
// handshake outputs from frame-level arithmetic: a start bit driven right
// after edge p is seen as START from edge E0=p+3; data bit j is shifted in the
// cycle beginning at E0+C/2+(j+1)*C-1; the stop bit is sampled in the cycle
// beginning at E0+C/2+(N+1)*C-1 and the completion shows from the next cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int N = 8;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rx = 1'b1;
  logic         sipo_clr, sipo_shift, sipo_data;
  logic [N-1:0] sipo_q = '0;
  logic [N-1:0] data;
  logic         valid;
  logic         ready = 1'b0;
  logic         ferr, ovr;

  uart_rx_ctrl #(.N(N), .CLKS_PER_BIT(C)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_sipo_clr  (sipo_clr),
    .o_sipo_shift(sipo_shift),
    .o_sipo_data (sipo_data),
    .i_sipo_q    (sipo_q),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overrun   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External sipo: new bit enters the MSB and shifts right.
  always @(posedge clk) begin
    if (sipo_clr) sipo_q <= '0;
    else if (sipo_shift) sipo_q <= {sipo_data, sipo_q[N-1:1]};
  end

  // Ready source: 0 = low, 1 = high, 2 = random, 3 = one pulse at rpulse.
  int rmode = 0;
  int rpulse = -1;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready = 1'b0;
      1: ready = 1'b1;
      2: ready = 1'($urandom_range(0, 1));
      default: ready = (cyc == rpulse);
    endcase
  end

  int tot = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected events keyed by the cycle in which they are visible.
  bit           ev_clr[int];
  logic         ev_shift[int];
  bit           ev_stop[int];
  logic [N-1:0] ev_data[int];

  // Reference state for the registered outputs.
  logic         m_valid = 1'b0;
  logic [N-1:0] m_data = '0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;

  // Observation bookkeeping used by the literal checks.
  int n_clr = 0, n_shift = 0, n_ferr = 0, n_ovr = 0;
  int clr_cyc = 0, first_sh_cyc = 0, sh_since_clr = 0, vrise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [N-1:0] acc_q[$];

  always @(negedge clk) begin
    int c;
    logic e_clr, e_sh;
    c = cyc;
    e_clr = rst_n && ev_clr.exists(c);
    e_sh  = rst_n && ev_shift.exists(c);
    chk("sipo_clr", 32'(sipo_clr), 32'(e_clr));
    chk("sipo_shift", 32'(sipo_shift), 32'(e_sh));
    if (e_sh) chk("sipo_data", 32'(sipo_data), 32'(ev_shift[c]));
    chk("valid", 32'(valid), rst_n ? 32'(m_valid) : 32'd0);
    chk("data", 32'(data), rst_n ? 32'(m_data) : 32'd0);
    chk("frame_err", 32'(ferr), rst_n ? 32'(m_ferr) : 32'd0);
    chk("overrun", 32'(ovr), rst_n ? 32'(m_ovr) : 32'd0);

    if (sipo_clr) begin n_clr++; clr_cyc = c; sh_since_clr = 0; end
    if (sipo_shift) begin
      if (sh_since_clr == 0) first_sh_cyc = c;
      sh_since_clr++;
      n_shift++;
    end
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (valid && !prev_valid) vrise_cyc = c;
    prev_valid = valid;
    if (valid && ready) acc_q.push_back(data);

    // Next-cycle reference values.
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (ev_stop.exists(c)) begin
        if (!ev_stop[c]) begin
          m_ferr = 1'b1;
          if (m_valid && ready) m_valid = 1'b0;
        end else if (!m_valid || ready) begin
          m_data  = ev_data[c];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  // Drives a frame starting now; cut < N drives only that many data bits.
  task automatic send(input logic [N-1:0] d, input bit stop_ok, input int stop_len, input int cut);
    int e0;
    e0 = cyc + 3;
    ev_clr[e0] = 1'b1;
    for (int j = 0; j < cut; j++) ev_shift[e0 + C/2 + (j+1)*C - 1] = d[j];
    if (cut == N) begin
      ev_stop[e0 + C/2 + (N+1)*C - 1] = stop_ok;
      ev_data[e0 + C/2 + (N+1)*C - 1] = d;
    end
    line(1'b0, C);
    for (int j = 0; j < cut; j++) line(d[j], C);
    if (cut == N) begin
      if (stop_ok) line(1'b1, C);
      else begin
        line(1'b0, stop_len);
        rx = 1'b1;
      end
    end
  endtask

  task automatic glitch(input int len);
    ev_clr[cyc + 3] = 1'b1;
    line(1'b0, len);
    line(1'b1, C);
  endtask

  task automatic drain_valid();
    rmode = 1;
    tick(); tick();
    rmode = 0;
    tick(); tick();
  endtask

  initial begin
    int b_clr, b_sh, b_ferr, b_ovr;

    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset strobes", {28'd0, sipo_clr, sipo_shift, ferr, ovr}, 32'd0);
    rst_n = 1'b1;
    line(1'b1, 5);

    // Clean 0xA5 frame with no consumer.
    b_sh = n_shift;
    send(8'hA5, 1'b1, C, N);
    line(1'b1, 40);
    chk("A5 shift count", 32'(n_shift - b_sh), 32'd8);
    chk("A5 first shift offset", 32'(first_sh_cyc - clr_cyc), 32'd23);
    chk("A5 valid offset", 32'(vrise_cyc - clr_cyc), 32'd152);
    chk("A5 data held", 32'(data), 32'hA5);
    chk("A5 valid held", 32'(valid), 32'd1);
    rmode = 3;
    rpulse = cyc + 1;
    tick(); tick(); tick();
    chk("A5 valid after accept", 32'(valid), 32'd0);
    rmode = 0;

    // Short low pulse while idle.
    b_clr = n_clr; b_sh = n_shift; b_ferr = n_ferr;
    glitch(4);
    line(1'b1, 10);
    chk("glitch clr count", 32'(n_clr - b_clr), 32'd1);
    chk("glitch shift count", 32'(n_shift - b_sh), 32'd0);
    chk("glitch ferr count", 32'(n_ferr - b_ferr), 32'd0);
    chk("glitch valid", 32'(valid), 32'd0);

    // Stop bit held low, then a clean frame.
    b_ferr = n_ferr; b_clr = n_clr;
    send(8'h3C, 1'b0, 40, N);
    line(1'b1, 5);
    chk("break ferr count", 32'(n_ferr - b_ferr), 32'd1);
    chk("break clr count", 32'(n_clr - b_clr), 32'd1);
    chk("break valid", 32'(valid), 32'd0);
    send(8'h55, 1'b1, C, N);
    line(1'b1, 4);
    chk("after break data", 32'(data), 32'h55);
    drain_valid();

    // Overrun: two frames without a consumer.
    b_ovr = n_ovr;
    send(8'h11, 1'b1, C, N);
    send(8'h22, 1'b1, C, N);
    line(1'b1, 4);
    chk("overrun data", 32'(data), 32'h11);
    chk("overrun valid", 32'(valid), 32'd1);
    chk("overrun count", 32'(n_ovr - b_ovr), 32'd1);
    drain_valid();

    // Same pair, consumer ready exactly in the second stop-sample cycle.
    b_ovr = n_ovr;
    rmode = 3;
    send(8'h11, 1'b1, C, N);
    rpulse = cyc + 2 + C/2 + (N+1)*C;
    send(8'h22, 1'b1, C, N);
    line(1'b1, 4);
    chk("swap data", 32'(data), 32'h22);
    chk("swap valid", 32'(valid), 32'd1);
    chk("swap overrun count", 32'(n_ovr - b_ovr), 32'd0);
    rmode = 0;
    drain_valid();

    // Reset in the middle of a frame.
    send(8'hFF, 1'b1, C, 4);
    rst_n = 1'b0;
    ev_clr.delete(); ev_shift.delete(); ev_stop.delete(); ev_data.delete();
    rx = 1'b1;
    #1;
    chk("midreset outputs", {22'd0, data, valid, sipo_clr, sipo_shift, sipo_data, ferr, ovr}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    line(1'b1, 3);
    send(8'h0F, 1'b1, C, N);
    line(1'b1, 4);
    chk("post reset data", 32'(data), 32'h0F);
    drain_valid();

    // Back-to-back frames with a ready consumer.
    b_ferr = n_ferr; b_ovr = n_ovr;
    acc_q.delete();
    rmode = 1;
    send(8'h01, 1'b1, C, N);
    send(8'h80, 1'b1, C, N);
    line(1'b1, 4);
    chk("b2b accepted count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("b2b first", 32'(acc_q[0]), 32'h01);
      chk("b2b second", 32'(acc_q[1]), 32'h80);
    end
    chk("b2b errors", 32'((n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);
    rmode = 0;

    // Randomized traffic against the reference.
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        send(N'($urandom), 1'b1, C, N);
        line(1'b1, $urandom_range(0, 20));
      end else if (kind < 9) begin
        send(N'($urandom), 1'b0, $urandom_range(C/2 + 4, 3*C), N);
        line(1'b1, $urandom_range(2, 20));
      end else begin
        glitch($urandom_range(1, C/2));
      end
    end
    line(1'b1, 2*C);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
